// File: rtl/frame_pkg.sv
// Shared constants, header layout and parser state type for the frame parser.
package frame_pkg;

    localparam int HDR_BYTES = 16;
    localparam int HDR_W     = HDR_BYTES * 8;

    localparam int DA_OFF = 0;
    localparam int SA_OFF = 6;
    localparam int LT_OFF = 12;
    localparam int SW_OFF = 14;

    localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_PAYLOAD,
        ST_DROP
    } parse_state_t;

    // Header is big-endian: byte at offset 0 occupies the top bits of the vector.
    function automatic logic [47:0] hdr_field(input logic [HDR_W-1:0] hdr,
                                              input int off,
                                              input int len);
        logic [47:0] f;
        f = '0;
        for (int i = 0; i < len; i++) begin
            f = {f[39:0], hdr[(HDR_BYTES - off - i) * 8 - 1 -: 8]};
        end
        return f;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream skid buffer with a registered output stage.
module axis_skid_buffer #(
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [DATA_W-1:0] skid_data;
    logic              skid_valid;

    // Ready depends only on registered state, so upstream sees no path from out_ready.
    assign in_ready = !skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (out_ready || !out_valid) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_data <= in_data;
                end
            end
        end else if (in_valid && !skid_valid) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/frame_parser.sv
// Strips and validates a 16-byte DA/SA/LinkType/SyncWord header and forwards the payload.
// Define FRAME_PARSER_DA_FILTER_EN to add Local_Address and destination filtering.
module frame_parser
    import frame_pkg::*;
#(
    parameter int PS_W = 14
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic [7:0]      s_axis_tdata,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    input  logic            s_axis_tlast,
    output logic [7:0]      m_axis_tdata,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic            m_axis_tlast,
    input  logic [15:0]     Link_Type,
    input  logic [15:0]     SyncWord,
    input  logic [PS_W-1:0] Packet_Size,
`ifdef FRAME_PARSER_DA_FILTER_EN
    input  logic [47:0]     Local_Address,
`endif
    output logic [47:0]     Destination_Address,
    output logic [47:0]     Source_Address,
    output logic            hdr_valid,
    output logic            frame_ok,
    output logic            err_hdr,
    output logic            err_runt,
    output logic            err_len
);

    localparam logic [3:0] HDR_LAST = 4'(HDR_BYTES - 1);

    parse_state_t    state;
    logic [HDR_W-9:0] hdr_sr;
    logic [3:0]      hdr_cnt;
    logic [PS_W-1:0] pay_cnt;
    logic [PS_W-1:0] pay_next;
    logic [PS_W-1:0] cfg_ps;
    logic [15:0]     cfg_lt;
    logic [15:0]     cfg_sw;
`ifdef FRAME_PARSER_DA_FILTER_EN
    logic [47:0]     cfg_la;
`endif

    logic [HDR_W-1:0] hdr_full;
    logic [47:0]      rx_da;
    logic [47:0]      rx_sa;
    logic [15:0]      rx_lt;
    logic [15:0]      rx_sw;
    logic             hdr_match;
    logic             at_limit;
    logic             s_fire;

    logic             skid_in_valid;
    logic             skid_in_ready;
    logic [8:0]       skid_in_data;
    logic [8:0]       skid_out_data;

    // Byte 15 is still on the bus when the header is judged, so splice it in directly.
    assign hdr_full = {hdr_sr, s_axis_tdata};
    assign rx_da    = hdr_field(hdr_full, DA_OFF, 6);
    assign rx_sa    = hdr_field(hdr_full, SA_OFF, 6);
    assign rx_lt    = 16'(hdr_field(hdr_full, LT_OFF, 2));
    assign rx_sw    = 16'(hdr_field(hdr_full, SW_OFF, 2));

`ifdef FRAME_PARSER_DA_FILTER_EN
    assign hdr_match = (rx_lt == cfg_lt) && (rx_sw == cfg_sw) &&
                       ((rx_da == cfg_la) || (rx_da == BCAST_ADDR));
`else
    assign hdr_match = (rx_lt == cfg_lt) && (rx_sw == cfg_sw);
`endif

    assign pay_next = pay_cnt + PS_W'(1);
    assign at_limit = (cfg_ps != '0) && (pay_next == cfg_ps);

    always_comb begin
        case (state)
            ST_PAYLOAD: s_axis_tready = skid_in_ready;
            default:    s_axis_tready = 1'b1;
        endcase
    end

    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign skid_in_valid = (state == ST_PAYLOAD) && s_axis_tvalid;
    // Reaching Packet_Size without tlast truncates the frame, so force tlast on that byte.
    assign skid_in_data  = {s_axis_tlast || at_limit, s_axis_tdata};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state               <= ST_HDR;
            hdr_sr              <= '0;
            hdr_cnt             <= '0;
            pay_cnt             <= '0;
            cfg_ps              <= '0;
            cfg_lt              <= '0;
            cfg_sw              <= '0;
`ifdef FRAME_PARSER_DA_FILTER_EN
            cfg_la              <= '0;
`endif
            Destination_Address <= '0;
            Source_Address      <= '0;
            hdr_valid           <= 1'b0;
            frame_ok            <= 1'b0;
            err_hdr             <= 1'b0;
            err_runt            <= 1'b0;
            err_len             <= 1'b0;
        end else begin
            hdr_valid <= 1'b0;
            frame_ok  <= 1'b0;
            err_hdr   <= 1'b0;
            err_runt  <= 1'b0;
            err_len   <= 1'b0;

            if (s_fire) begin
                case (state)
                    ST_HDR: begin
                        hdr_sr <= {hdr_sr[HDR_W-17:0], s_axis_tdata};
                        if (hdr_cnt == '0) begin
                            cfg_ps <= Packet_Size;
                            cfg_lt <= Link_Type;
                            cfg_sw <= SyncWord;
`ifdef FRAME_PARSER_DA_FILTER_EN
                            cfg_la <= Local_Address;
`endif
                        end
                        if (s_axis_tlast) begin
                            err_runt <= 1'b1;
                            hdr_cnt  <= '0;
                        end else if (hdr_cnt == HDR_LAST) begin
                            hdr_cnt <= '0;
                            if (hdr_match) begin
                                hdr_valid           <= 1'b1;
                                Destination_Address <= rx_da;
                                Source_Address      <= rx_sa;
                                pay_cnt             <= '0;
                                state               <= ST_PAYLOAD;
                            end else begin
                                err_hdr <= 1'b1;
                                state   <= ST_DROP;
                            end
                        end else begin
                            hdr_cnt <= hdr_cnt + 4'd1;
                        end
                    end

                    ST_PAYLOAD: begin
                        pay_cnt <= pay_next;
                        if (s_axis_tlast) begin
                            if ((cfg_ps == '0) || at_limit) begin
                                frame_ok <= 1'b1;
                            end else begin
                                err_len <= 1'b1;
                            end
                            state <= ST_HDR;
                        end else if (at_limit) begin
                            err_len <= 1'b1;
                            state   <= ST_DROP;
                        end
                    end

                    default: begin
                        if (s_axis_tlast) begin
                            state <= ST_HDR;
                        end
                    end
                endcase
            end
        end
    end

    axis_skid_buffer #(
        .DATA_W(9)
    ) u_skid (
        .clk      (ACLK),
        .rst      (ARESET),
        .in_data  (skid_in_data),
        .in_valid (skid_in_valid),
        .in_ready (skid_in_ready),
        .out_data (skid_out_data),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready)
    );

    assign {m_axis_tlast, m_axis_tdata} = skid_out_data;

endmodule
